fifo_byte_packer: RTL and testbench

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

---
 rtl/fifo_byte_packer_if.sv | 39 +++
 rtl/fifo_byte_packer.sv | 121 ++++++++++++
 tb/tb_fifo_byte_packer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_byte_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_byte_packer_if : FIFO read side and packed-word output bus           |
// | flush/out_bytes exist only when PACKER_FLUSH_EN is defined. Rev 1.0       |
// +--------------------------------------------------------------------------+
interface fifo_byte_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  logic                         fifo_empty;
  logic                         fifo_rd_en;
  logic [DATA_WIDTH-1:0]        fifo_rd_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH*PACK-1:0]   out_data;
`ifdef PACKER_FLUSH_EN
  logic                         flush;
  logic [3:0]                   out_bytes;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready, flush,
    output fifo_rd_en, out_valid, out_data, out_bytes
  );
  modport slave (
    output fifo_empty, fifo_rd_data, out_ready, flush,
    input  fifo_rd_en, out_valid, out_data, out_bytes
  );
`else
  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data
  );
  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_valid, out_data
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fifo_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_byte_packer : reads PACK bytes from a FIFO, presents one packed word |
// | Optional partial-word flush via macro PACKER_FLUSH_EN.       Rev 1.0      |
// +--------------------------------------------------------------------------+
module fifo_byte_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fifo_byte_packer_if.master  bus
);
  localparam int c_CNT_W = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [c_CNT_W-1:0]              r_cnt, w_cnt_nxt;
  logic                            r_inflight;
  logic [PACK-1:0][DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                            w_rd_en;
  logic                            w_room;
  logic                            w_pending;
`ifdef PACKER_FLUSH_EN
  logic                            r_pending, w_pending_nxt;
  logic [c_CNT_W-1:0]              r_out_bytes, w_out_bytes_nxt;

  assign w_pending = r_pending;
`else
  assign w_pending = 1'b0;
`endif

  // Counting the outstanding read keeps the last request from overshooting a full word.
  assign w_room = (r_cnt + c_CNT_W'(r_inflight)) < c_CNT_W'(PACK);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_rd_en     = 1'b0;
`ifdef PACKER_FLUSH_EN
    w_pending_nxt   = r_pending;
    w_out_bytes_nxt = r_out_bytes;
`endif
    case (r_state)
      FILL: begin
        w_rd_en = !rst && !bus.fifo_empty && !w_pending && w_room;
        if (r_inflight) begin
          for (int i = 0; i < PACK; i++) begin
            if (r_cnt == c_CNT_W'(i)) w_data_nxt[i] = bus.fifo_rd_data;
          end
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
          if (w_cnt_nxt == c_CNT_W'(PACK)) begin
            w_state_nxt = HOLD;
`ifdef PACKER_FLUSH_EN
            w_out_bytes_nxt = c_CNT_W'(PACK);
            w_pending_nxt   = 1'b0;
`endif
          end
        end
`ifdef PACKER_FLUSH_EN
        else if (r_pending) begin
          // Pending flush resolves only once no read is outstanding.
          w_pending_nxt = 1'b0;
          if (r_cnt != '0) begin
            w_state_nxt     = HOLD;
            w_out_bytes_nxt = r_cnt;
          end
        end
        if (bus.flush && (w_state_nxt == FILL)) w_pending_nxt = 1'b1;
`endif
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = FILL;
          w_cnt_nxt   = '0;
          w_data_nxt  = '0;
`ifdef PACKER_FLUSH_EN
          w_out_bytes_nxt = '0;
`endif
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_data      <= '0;
`ifdef PACKER_FLUSH_EN
      r_pending   <= 1'b0;
      r_out_bytes <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_inflight  <= w_rd_en;
      r_data      <= w_data_nxt;
`ifdef PACKER_FLUSH_EN
      r_pending   <= w_pending_nxt;
      r_out_bytes <= w_out_bytes_nxt;
`endif
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_data   = r_data;
`ifdef PACKER_FLUSH_EN
  assign bus.out_bytes  = r_out_bytes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_byte_packer : self-checking bench with FIFO model and scoreboard  |
// | Flush checks compile in with PACKER_FLUSH_EN.                Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_fifo_byte_packer;
  localparam int DW = 8;
  localparam int PK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_byte_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();
  fifo_byte_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Upstream FIFO model: data appears the cycle after a read strobe.
  logic [7:0] mem [0:1023];
  int         wp = 0;
  int         rp = 0;
  logic       stall = 1'b1;
  logic       fifo_clr = 1'b0;
  logic [7:0] rd_data = 8'h00;
  int         bad_reads = 0;

  assign bus.fifo_empty   = (wp == rp) || stall;
  assign bus.fifo_rd_data = rd_data;

  always @(posedge clk) begin
    if (fifo_clr) rp <= wp;
    else if (bus.fifo_rd_en) begin
      if (bus.fifo_empty) bad_reads <= bad_reads + 1;
      else begin
        rd_data <= mem[rp % 1024];
        rp      <= rp + 1;
      end
    end
  end

  // Output monitor: records every accepted word.
  logic [31:0] got_words [0:511];
  logic [3:0]  got_bytes [0:511];
  int          got_n = 0;
  int          overlap_err = 0;
  int          rst_rd_err = 0;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_words[got_n] = bus.out_data;
`ifdef PACKER_FLUSH_EN
      got_bytes[got_n] = bus.out_bytes;
`else
      got_bytes[got_n] = 4'(PK);
`endif
      got_n = got_n + 1;
    end
    if (bus.out_valid && bus.fifo_rd_en) overlap_err = overlap_err + 1;
    if (rst && bus.fifo_rd_en) rst_rd_err = rst_rd_err + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp % 1024] = b;
    wp = wp + 1;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got_n < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(got_n >= n), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_rd, t_v, nv, g0, r0, k, held_bad, rd_seen, pushed;
    logic [31:0] expw;
    logic [7:0]  b;
    logic [7:0]  q [$];

    tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
    tbl[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
    tbl[3] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'hFE7F0180};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};

    bus.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    #1 rst = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));

    // Reset with a non-empty FIFO
    repeat (3) @(negedge clk);
    chk("reset_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);

    // Streaming, FIFO never empty, latency from first read to out_valid
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    t_rd = -1; t_v = -1; nv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en && t_rd < 0) t_rd = c;
      if (bus.out_valid) begin
        nv++;
        if (t_v < 0) t_v = c;
      end
    end
    chk("stream_latency", 64'(t_v - t_rd), 64'(PK + 1));
    chk("stream_valid_cycles", 64'(nv), 64'd2);
    chk("stream_word_count", 64'(got_n), 64'd2);
    chk("stream_w0", 64'(got_words[0]), 64'h03020100);
    chk("stream_w1", 64'(got_words[1]), 64'h07060504);
`ifdef PACKER_FLUSH_EN
    chk("stream_full_bytes", 64'(got_bytes[0]), 64'd4);
`endif

    // Backpressure
    tick();
    bus.out_ready = 1'b0;
    g0 = got_n;
    for (int i = 0; i < 8; i++) push(8'(i));
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    held_bad = 0; rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_data !== 32'h03020100 || !bus.out_valid) held_bad++;
      if (bus.fifo_rd_en) rd_seen++;
    end
    chk("bp_held", 64'(held_bad), 64'd0);
    chk("bp_no_read", 64'(rd_seen), 64'd0);
    chk("bp_no_accept", 64'(got_n - g0), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    wait_words(g0 + 2, 40, "bp_timeout");
    chk("bp_w0", 64'(got_words[g0]), 64'h03020100);
    chk("bp_w1", 64'(got_words[g0 + 1]), 64'h07060504);

    // Table-driven words
    for (int t = 0; t < 5; t++) begin
      g0 = got_n;
      push(tbl[t].b0); push(tbl[t].b1); push(tbl[t].b2); push(tbl[t].b3);
      wait_words(g0 + 1, 40, $sformatf("tbl%0d_timeout", t));
      chk($sformatf("tbl%0d_word", t), 64'(got_words[g0]), 64'(tbl[t].exp));
    end

    // Starvation: empty flag toggles every cycle
    tick();
    g0 = got_n;
    r0 = rp;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    k = 0;
    while (got_n == g0 && k < 60) begin
      stall = ~stall;
      tick();
      k++;
    end
    for (int i = 0; i < 6; i++) begin
      stall = ~stall;
      tick();
    end
    stall = 1'b0;
    chk("starve_word", 64'(got_words[g0]), 64'hA3A2A1A0);
    chk("starve_reads", 64'(rp - r0), 64'd4);
    chk("starve_words", 64'(got_n - g0), 64'd1);

    // Mid-word reset
    tick();
    g0 = got_n;
    push(8'h55); push(8'h66);
    repeat (5) tick();
    rst = 1'b1;
    fifo_clr = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_data", 64'(bus.out_data), 64'd0);
    tick();
    rst = 1'b0;
    fifo_clr = 1'b0;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    wait_words(g0 + 1, 40, "midrst_timeout");
    chk("midrst_word", 64'(got_words[g0]), 64'h13121110);

`ifdef PACKER_FLUSH_EN
    // Partial-word flush, then flush with nothing captured
    tick();
    g0 = got_n;
    push(8'h58); push(8'h0B);
    repeat (5) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_words(g0 + 1, 20, "flush_timeout");
    chk("flush_word", 64'(got_words[g0]), 64'h00000B58);
    chk("flush_bytes", 64'(got_bytes[g0]), 64'd2);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("flush_empty_no_valid", 64'(nv), 64'd0);
    tick();
`endif

    // Randomised traffic against a byte-stream reference
    g0 = got_n;
    pushed = 0;
    k = 0;
    while ((got_n - g0) < 50 && k < 6000) begin
      if (pushed < 200 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        push(b);
        q.push_back(b);
        pushed++;
      end
      stall = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      k++;
    end
    stall = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_count", 64'(got_n - g0), 64'd50);
    for (int w = 0; w < 50; w++) begin
      expw = 32'd0;
      for (int j = 0; j < PK; j++) expw = expw + (32'(q[w * PK + j]) << (8 * j));
      chk($sformatf("rand_w%0d", w), 64'(got_words[g0 + w]), 64'(expw));
    end

    repeat (5) tick();
    chk("no_read_when_empty", 64'(bad_reads), 64'd0);
    chk("no_read_in_hold", 64'(overlap_err), 64'd0);
    chk("no_read_in_reset", 64'(rst_rd_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
